addsub_pipe: RTL and testbench

- Registered, handshaked front end for the N-bit ripple add/sub datapath.
- Accepts operand pairs plus an op select through a valid/ready input and pushes them through a 2-stage pipeline: operand register, then result/flag register.
- Delivers the result with carry, signed overflow, zero and negative flags through a valid/ready output.
- Sits between the instruction/operand sequencer (upstream) and result writeback (downstream).

---
 rtl/addsub_pkg.sv | 24 ++
 rtl/addsub_core.sv | 33 +++
 rtl/addsub_pipe.sv | 130 +++++++++++++
 tb/tb_addsub_pipe.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/sub block: op encoding,
// the result flag bundle and a 1-bit full-adder helper.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
        logic neg;
    } flags_t;

    // One full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
        logic s;
        logic c;
        s = a ^ b ^ cin;
        c = (a & b) | (cin & (a ^ b));
        return {c, s};
    endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational N-bit ripple add/sub. Subtraction is A + ~B + 1, so the
// op select doubles as the carry into bit 0.
module addsub_core
    import addsub_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    logic [N:0]   w_carry;
    logic [N-1:0] w_b_eff;

    assign w_carry[0] = sub;

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_bit
            assign w_b_eff[i] = b[i] ^ sub;
            assign {w_carry[i+1], sum[i]} = full_add(a[i], w_b_eff[i], w_carry[i]);
        end
    endgenerate

    assign cout = w_carry[N];
    // Signed overflow: operands agree in sign but the result does not.
    assign ovf  = (a[N-1] == w_b_eff[N-1]) && (sum[N-1] != a[N-1]);

endmodule

// File: rtl/addsub_pipe.sv
// Two-stage valid/ready pipeline around addsub_core: stage 1 holds the
// operands, stage 2 holds the result and flags that drive the outputs.
// Optional feature macro: ADDSUB_PIPE_SATURATE_EN (adds in_sat, signed clamp
// on overflow).
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         in_sub,
`ifdef ADDSUB_PIPE_SATURATE_EN
    input  logic         in_sat,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
    output logic         out_cout,
    output logic         out_ovf,
    output logic         out_zero,
    output logic         out_neg
);

    logic         r_s1_valid;
    logic [N-1:0] r_s1_a;
    logic [N-1:0] r_s1_b;
    logic         r_s1_sub;
    logic         r_s1_sat;

    logic         r_s2_valid;
    logic [N-1:0] r_s2_sum;
    flags_t       r_s2_flags;

    logic         w_s1_advance;
    logic         w_in_xfer;
    logic         w_out_xfer;
    logic [N-1:0] w_core_sum;
    logic         w_core_cout;
    logic         w_core_ovf;
    logic [N-1:0] w_final_sum;
    flags_t       w_flags;
    logic         w_sat_req;

`ifdef ADDSUB_PIPE_SATURATE_EN
    assign w_sat_req = in_sat;
`else
    assign w_sat_req = 1'b0;
`endif

    // Stage 1 drains whenever stage 2 is empty or emptying this cycle, which
    // lets in_ready stay high at full throughput.
    assign w_s1_advance = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready     = !r_s1_valid || w_s1_advance;
    assign w_in_xfer    = in_valid && in_ready;
    assign w_out_xfer   = r_s2_valid && out_ready;

    addsub_core #(.N(N)) u_core (
        .a    (r_s1_a),
        .b    (r_s1_b),
        .sub  (r_s1_sub),
        .sum  (w_core_sum),
        .cout (w_core_cout),
        .ovf  (w_core_ovf)
    );

    // Optional clamp to the signed limit, then flags from the final value.
    always_comb begin
        w_final_sum = w_core_sum;
        if (r_s1_sat && w_core_ovf) begin
            if (r_s1_a[N-1] == 1'b0) begin
                w_final_sum = {1'b0, {(N-1){1'b1}}};
            end else begin
                w_final_sum = {1'b1, {(N-1){1'b0}}};
            end
        end else begin
            w_final_sum = w_core_sum;
        end
        w_flags.cout = w_core_cout;
        w_flags.ovf  = w_core_ovf;
        w_flags.zero = (w_final_sum == {N{1'b0}});
        w_flags.neg  = w_final_sum[N-1];
    end

    // Stage 1 operand register: load on input transfer, empty on advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= {N{1'b0}};
            r_s1_b     <= {N{1'b0}};
            r_s1_sub   <= OP_ADD;
            r_s1_sat   <= 1'b0;
        end else if (w_in_xfer) begin
            r_s1_valid <= 1'b1;
            r_s1_a     <= in_a;
            r_s1_b     <= in_b;
            r_s1_sub   <= in_sub;
            r_s1_sat   <= w_sat_req;
        end else if (w_s1_advance) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2 result register: load on advance, empty on output transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_sum   <= {N{1'b0}};
            r_s2_flags <= '{cout: 1'b0, ovf: 1'b0, zero: 1'b0, neg: 1'b0};
        end else if (w_s1_advance) begin
            r_s2_valid <= 1'b1;
            r_s2_sum   <= w_final_sum;
            r_s2_flags <= w_flags;
        end else if (w_out_xfer) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign out_valid = r_s2_valid;
    assign out_sum   = r_s2_sum;
    assign out_cout  = r_s2_flags.cout;
    assign out_ovf   = r_s2_flags.ovf;
    assign out_zero  = r_s2_flags.zero;
    assign out_neg   = r_s2_flags.neg;

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: directed steps plus randomized traffic, checked
// against an integer-arithmetic model and an in-flight queue.
module tb_addsub_pipe;

    localparam int N   = 4;
    localparam int MOD = 1 << N;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_a = '0;
    logic [N-1:0] in_b = '0;
    logic         in_sub = 1'b0;
    logic         sat = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] out_sum;
    logic         out_cout, out_ovf, out_zero, out_neg;

    int checks = 0;
    int failures = 0;
    logic last_acc;
    int acc_cnt;

    typedef struct {
        logic [N-1:0] sum;
        logic cout, ovf, zero, neg;
        int age;
    } ent_t;
    ent_t q[$];

    always #5 clk = ~clk;

    addsub_pipe #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
`ifdef ADDSUB_PIPE_SATURATE_EN
        .in_sat(sat),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
        .out_zero(out_zero), .out_neg(out_neg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result from signed/unsigned integer arithmetic.
    function automatic ent_t model(input int a, input int b, input bit sub, input bit s);
        ent_t e;
        int sa, sb, rs, u;
        sa = (a >= MOD/2) ? a - MOD : a;
        sb = (b >= MOD/2) ? b - MOD : b;
        rs = sub ? sa - sb : sa + sb;
        u  = sub ? a + MOD - b : a + b;
        e.cout = (u >= MOD);
        e.ovf  = (rs > MOD/2 - 1) || (rs < -MOD/2);
        e.sum  = N'(u % MOD);
`ifdef ADDSUB_PIPE_SATURATE_EN
        if (s && e.ovf) e.sum = (rs > 0) ? N'(MOD/2 - 1) : N'(MOD/2);
`endif
        e.zero = (e.sum == '0);
        e.neg  = e.sum[N-1];
        e.age  = 0;
        return e;
    endfunction

    // One clock: check handshake and output against the model, then advance.
    task automatic tick();
        logic ein, eov, ixf, oxf;
        #1;
        ein = (q.size() < 2) || out_ready;
        eov = (q.size() > 0) && (q[0].age >= 1);
        chk("in_ready", in_ready, ein);
        chk("out_valid", out_valid, eov);
        if (eov) begin
            chk("sum", out_sum, q[0].sum);
            chk("cout", out_cout, q[0].cout);
            chk("ovf", out_ovf, q[0].ovf);
            chk("zero", out_zero, q[0].zero);
            chk("neg", out_neg, q[0].neg);
        end
        ixf = in_valid && ein;
        oxf = eov && out_ready;
        @(posedge clk);
        #1;
        if (oxf) void'(q.pop_front());
        for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
        if (ixf) q.push_back(model(int'(in_a), int'(in_b), in_sub, sat));
        last_acc = ixf;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        q.delete();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_outs", {out_sum, out_cout, out_ovf, out_zero, out_neg}, '0);
    endtask

    task automatic set_op(input int a, input int b, input bit sub, input bit s);
        in_valid = 1'b1;
        in_a = N'(a);
        in_b = N'(b);
        in_sub = sub;
        sat = s;
    endtask

    task automatic one_op(input int a, input int b, input bit sub, input bit s);
        set_op(a, b, sub, s);
        tick();
        chk("accepted", last_acc, 1'b1);
        in_valid = 1'b0;
        chk("lat_cycle1", out_valid, 1'b0);
        tick();
        chk("lat_cycle2", out_valid, 1'b1);
        tick();
    endtask

    initial begin
        last_acc = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Directed arithmetic corner cases.
        one_op(5, 3, 1'b0, 1'b0);
        chk("5+3_sum_seen", out_valid, 1'b0);
        one_op(3, 5, 1'b1, 1'b0);
        one_op(7, 7, 1'b1, 1'b0);
        one_op(15, 1, 1'b0, 1'b0);
        one_op(8, 1, 1'b1, 1'b0);
`ifdef ADDSUB_PIPE_SATURATE_EN
        one_op(5, 3, 1'b0, 1'b1);
        one_op(8, 15, 1'b0, 1'b1);
        one_op(5, 3, 1'b0, 1'b0);
`endif

        // Back-to-back stream of 8 ops at full throughput.
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            set_op($urandom_range(0, MOD-1), $urandom_range(0, MOD-1), 1'($urandom), 1'($urandom));
            chk("stream_in_ready", in_ready, 1'b1);
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();

        // Backpressure: offer 3 ops with out_ready low; only 2 fit.
        out_ready = 1'b0;
        acc_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            set_op($urandom_range(0, MOD-1), $urandom_range(0, MOD-1), 1'($urandom), 1'($urandom));
            for (int w = 0; w < 4; w++) begin
                tick();
                if (last_acc) break;
            end
            if (last_acc) acc_cnt++;
        end
        chk("stall_accepted", acc_cnt, 2);
        chk("stall_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", in_ready, 1'b1);
        tick();
        chk("third_accepted", last_acc, 1'b1);
        in_valid = 1'b0;
        repeat (4) tick();

        // Randomized traffic with random backpressure.
        for (int k = 0; k < 300; k++) begin
            if (!in_valid || last_acc) begin
                if ($urandom_range(0, 3) != 0)
                    set_op($urandom_range(0, MOD-1), $urandom_range(0, MOD-1), 1'($urandom), 1'($urandom));
                else
                    in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("drained", q.size(), 0);

        // Reset with two ops in flight: nothing stale may come out.
        out_ready = 1'b0;
        set_op(5, 3, 1'b0, 1'b0);
        tick();
        set_op(6, 6, 1'b0, 1'b0);
        tick();
        chk("two_in_flight", q.size(), 2);
        do_reset();
        out_ready = 1'b1;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
